ec1_run_sequencer: RTL
======================

# ec1_run_sequencer

Job sequencer that owns the EC1 datapath and runs it once per submitted operand. It accepts an 8-bit operand over a valid/ready handshake and holds EC1 in reset for a fixed window with the operand applied. It then releases reset, waits for EC1 to raise H (or a timeout), and presents the captured led value on a valid/ready result port. It sits between any host-side requester (switch debouncer, UART loader, test FSM) and a single EC1 instance, replacing hand-driven Reset/A sequencing.

## Interface
- RST_CYCLES, 5: cycles EC1 is held in reset with the new operand before release; legal range 1..255.
- TIMEOUT, 1000: maximum RUN cycles to wait for H; legal range 2..65535.
- clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset of this block.
- job_valid  input  1  requester has an operand.
- job_a  input  8  operand for EC1 input A.
- job_ready  output  1  block can accept a job.
- ec_A  output  8  drives EC1.A.
- ec_Reset  output  1  drives EC1.Reset.
- ec_led  input  8  from EC1.led.
- ec_H  input  1  from EC1.H (halt/done).
- result_valid  output  1  result available.
- result_ready  input  1  consumer takes result.
- result_led  output  8  captured ec_led.
- result_timeout  output  1  1 = run ended by timeout, not H.
- busy  output  1  state is not IDLE.
- jobs_done  output  8  completed-job count, wraps 255->0.

## Operation
- One clock (clk); Reset is synchronous and active-high. Reset has priority over every other event.
- Reset values: state IDLE, ec_A=0, ec_Reset=1, result_valid=0, result_led=0, result_timeout=0, jobs_done=0, busy=0, internal counter 0.
- States: IDLE, RESET, RUN, DONE.
- IDLE: job_ready=1, ec_Reset=1, ec_A holds last operand. A cycle with job_valid=1 sets a_reg=job_a and cnt=0, then the next state is RESET. The handshake is ignored in any cycle with Reset=1.
- RESET: ec_Reset=1, ec_A=a_reg, cnt increments. At the edge where cnt==RST_CYCLES-1, the next state is RUN with cnt=0.
- RUN: ec_Reset=0, ec_A=a_reg, ec_H sampled every cycle.
  - ec_H=1: capture result_led=ec_led, result_timeout=0, go to DONE.
  - Else cnt==TIMEOUT-1: capture result_led=ec_led, result_timeout=1, go to DONE.
  - Else cnt++.
  - ec_H=1 on the same cycle as the timeout limit: H wins, result_timeout=0.
- DONE: result_valid=1, ec_Reset=1, ec_A=a_reg. A cycle with result_ready=1 sends the state to IDLE and increments jobs_done (mod 256). result_led and result_timeout are stable while result_valid=1 and hold their value after it drops.
- job_ready=0 in RESET, RUN and DONE. New jobs are not queued; job_valid may stay high and is accepted on return to IDLE.
- job_ready and result_valid are decoded from state only. Neither depends combinationally on job_valid or result_ready.
- Reset mid-operation (any state): returns to IDLE with reset values next edge. The in-flight job is dropped and jobs_done is not incremented.

## Timing
- Job accepted at edge E0. ec_Reset=1 with ec_A=job_a during cycles E0..E0+RST_CYCLES.
- First RUN cycle (ec_Reset=0) starts at edge E0+RST_CYCLES.
- If ec_H is first 1 in RUN cycle k (k=0 is the first), the state is DONE and result_valid=1 from edge E0+RST_CYCLES+k+1.
- Timeout: result_valid=1 from edge E0+RST_CYCLES+TIMEOUT.
- Result handshake at edge Ed gives IDLE and job_ready=1 from Ed+1. Minimum spacing between job acceptances is RST_CYCLES+3 cycles.
- ec_H is ignored outside RUN.

## Test plan
- Reset=1 for 5 cycles, then 0 → job_ready=1, ec_Reset=1, ec_A=0, result_valid=0, jobs_done=0.
- Stub EC1 raises H 10 cycles after release with led=A+1; job_a=0x01, result_ready=1 → ec_Reset high exactly 5 cycles (RST_CYCLES=5), result_valid 11 cycles after release, result_led=0x02, result_timeout=0, jobs_done=1.
- Stub never raises H, TIMEOUT=20, job_a=0x03 → result_valid exactly 20 cycles after release, result_timeout=1, result_led=current stub led.
- Back-to-back jobs 0x01,0x02,0x03,0x04,0xFF with job_valid held high and result_ready=0 for 7 cycles on job 2 → result held stable while stalled, no job accepted until DONE exits, five results in order, jobs_done=5.
- H asserted exactly on cycle TIMEOUT-1 → result_timeout=0. Reset asserted in RUN → IDLE next edge, ec_Reset=1, result_valid=0, jobs_done unchanged.
- 256 completed jobs → jobs_done wraps to 0.

Source files
------------

// File: rtl/ec1_run_sequencer_if.sv
// Handshake, EC1 drive and status bundle for ec1_run_sequencer.
// The slave side is the sequencer; the master side is the requester, consumer and EC1 model.
interface ec1_run_sequencer_if;
  logic       job_valid;
  logic [7:0] job_a;
  logic       job_ready;
  logic [7:0] ec_A;
  logic       ec_Reset;
  logic [7:0] ec_led;
  logic       ec_H;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result_led;
  logic       result_timeout;
  logic       busy;
  logic [7:0] jobs_done;

  modport slave (
    input  job_valid, job_a, ec_led, ec_H, result_ready,
    output job_ready, ec_A, ec_Reset, result_valid, result_led, result_timeout, busy, jobs_done
  );
  modport master (
    output job_valid, job_a, ec_led, ec_H, result_ready,
    input  job_ready, ec_A, ec_Reset, result_valid, result_led, result_timeout, busy, jobs_done
  );
endinterface

// File: rtl/ec1_run_sequencer.sv
// Runs one EC1 job per accepted operand: hold in reset, release, wait for H or timeout,
// then present the captured led value until the consumer takes it.
module ec1_run_sequencer #(
  parameter int RST_CYCLES = 5,
  parameter int TIMEOUT    = 1000
) (
  input logic                 clk,
  input logic                 Reset,
  ec1_run_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_a, r_led, r_jobs;
  logic        r_tmo;
  logic        w_accept, w_capture, w_capture_tmo, w_complete;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_capture_tmo = 1'b0;
    w_complete    = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.job_valid) begin
        w_accept    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_RESET;
      end
      S_RESET: if (r_cnt == RST_LAST) begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_RUN;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
      // H has priority over the timeout limit landing on the same cycle
      S_RUN: if (bus.ec_H) begin
        w_capture   = 1'b1;
        w_state_nxt = S_DONE;
      end else if (r_cnt == TMO_LAST) begin
        w_capture     = 1'b1;
        w_capture_tmo = 1'b1;
        w_state_nxt   = S_DONE;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
      S_DONE: if (bus.result_ready) begin
        w_complete  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_led   <= '0;
      r_tmo   <= 1'b0;
      r_jobs  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept)   r_a    <= bus.job_a;
      if (w_capture)  begin
        r_led <= bus.ec_led;
        r_tmo <= w_capture_tmo;
      end
      if (w_complete) r_jobs <= r_jobs + 8'd1;
    end
  end

  // Handshake outputs are pure state decodes so neither side sees a combinational loop
  assign bus.job_ready      = (r_state == S_IDLE);
  assign bus.result_valid   = (r_state == S_DONE);
  assign bus.ec_Reset       = (r_state != S_RUN);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.ec_A           = r_a;
  assign bus.result_led     = r_led;
  assign bus.result_timeout = r_tmo;
  assign bus.jobs_done      = r_jobs;
endmodule
